// File: rtl/lcd_char_responder.sv
// lcd_char_responder: HD44780-compatible 8-bit character LCD responder with a
// 2x16 DDRAM, busy flag, address/data reads and a random-access readback port.
// Optional feature macro: LCD_BUSY_EMU_EN. When defined, accepted accesses hold
// busy for BUSY_CMD_CYC / BUSY_CLR_CYC cycles. When undefined, busy is asserted
// only during the 32-cycle clear fill.
module lcd_char_responder #(
    parameter int BUSY_CMD_CYC = 2000,
    parameter int BUSY_CLR_CYC = 76000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [4:0] cursor_addr,
    output logic       display_on,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic       cmd_err
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} state_t;

    state_t     state, state_n;

    // bus capture
    logic       e_s1, e_s2, e_d, fall;
    logic       bus_rs, bus_rw;
    logic [7:0] bus_data;
    logic       pend, c_rs, c_rw;
    logic [7:0] c_data;

    // display state
    logic [7:0] ddram [32];
    logic [4:0] cursor, cursor_n, step_addr;
    logic [4:0] ptr, ptr_n;
    logic       id, id_n, disp, disp_n, err_n;

    // RAM write port and wait request
    logic       ram_we;
    logic [4:0] ram_wa;
    logic [7:0] ram_wd;
    logic       go_wait, wait_clr;
    logic [6:0] ddr_a;

`ifdef LCD_BUSY_EMU_EN
    logic [CNT_W-1:0] cnt, cnt_n;
`else
    logic unused_cfg;
    assign unused_cfg = wait_clr ^ (BUSY_CMD_CYC > 0) ^ (BUSY_CLR_CYC > 0) ^ (CNT_W > 0);
`endif

    // Synchronize E (2 flops + edge history); register rs/rw/data once so they line up with e_s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_s1     <= 1'b0;
            e_s2     <= 1'b0;
            e_d      <= 1'b0;
            bus_rs   <= 1'b0;
            bus_rw   <= 1'b0;
            bus_data <= 8'h00;
        end else begin
            e_s1     <= lcd_e;
            e_s2     <= e_s1;
            e_d      <= e_s2;
            bus_rs   <= lcd_rs;
            bus_rw   <= lcd_rw;
            bus_data <= lcd_data_in;
        end
    end

    assign fall = e_d & ~e_s2;

    // Hold the bus values seen at the falling edge; they are committed on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            c_rs   <= 1'b0;
            c_rw   <= 1'b0;
            c_data <= 8'h00;
        end else begin
            pend <= fall;
            if (fall) begin
                c_rs   <= bus_rs;
                c_rw   <= bus_rw;
                c_data <= bus_data;
            end
        end
    end

    assign step_addr = id ? cursor + 5'd1 : cursor - 5'd1;
    assign ddr_a     = c_data[6:0];

    // Next-state decode: command/data commit, clear fill sequencing, busy countdown.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cursor_n = cursor;
        id_n     = id;
        disp_n   = disp;
        err_n    = 1'b0;
        ram_we   = 1'b0;
        ram_wa   = cursor;
        ram_wd   = c_data;
        go_wait  = 1'b0;
        wait_clr = 1'b0;
`ifdef LCD_BUSY_EMU_EN
        cnt_n    = cnt;
`endif
        // while busy, only instruction (busy-flag) reads are allowed
        if (pend && state != S_IDLE && !(c_rw && !c_rs))
            err_n = 1'b1;

        case (state)
            S_IDLE: begin
                if (pend) begin
                    if (c_rw) begin
                        if (c_rs)
                            cursor_n = step_addr;
                    end else if (c_rs) begin
                        ram_we   = 1'b1;
                        cursor_n = step_addr;
                        go_wait  = 1'b1;
                    end else begin
                        casez (c_data)
                            8'b1???????: begin
                                if (ddr_a[6:4] == 3'b000) begin
                                    cursor_n = {1'b0, ddr_a[3:0]};
                                    go_wait  = 1'b1;
                                end else if (ddr_a[6:4] == 3'b100) begin
                                    cursor_n = {1'b1, ddr_a[3:0]};
                                    go_wait  = 1'b1;
                                end else begin
                                    err_n = 1'b1;
                                end
                            end
                            8'b01??????: err_n = 1'b1;
                            8'b001?????: begin
                                if (c_data[4]) go_wait = 1'b1;
                                else           err_n   = 1'b1;
                            end
                            8'b0001????: go_wait = 1'b1;
                            8'b00001???: begin
                                disp_n  = c_data[2];
                                go_wait = 1'b1;
                            end
                            8'b000001??: begin
                                id_n    = c_data[1];
                                go_wait = 1'b1;
                            end
                            8'b0000001?: begin
                                cursor_n = 5'd0;
                                go_wait  = 1'b1;
                                wait_clr = 1'b1;
                            end
                            8'b00000001: begin
                                state_n  = S_FILL;
                                ptr_n    = 5'd0;
                                cursor_n = 5'd0;
                                id_n     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_FILL: begin
                ram_we = 1'b1;
                ram_wa = ptr;
                ram_wd = 8'h20;
                ptr_n  = ptr + 5'd1;
                if (ptr == 5'd31) begin
                    go_wait  = 1'b1;
                    wait_clr = 1'b1;
                end
            end
            S_WAIT: begin
`ifdef LCD_BUSY_EMU_EN
                cnt_n = cnt - 1'b1;
                if (cnt == '0)
                    state_n = S_IDLE;
`else
                state_n = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase

        // counter holds remaining busy cycles minus one, so busy lasts exactly N cycles
        if (go_wait) begin
`ifdef LCD_BUSY_EMU_EN
            state_n = S_WAIT;
            cnt_n   = wait_clr ? CNT_W'(BUSY_CLR_CYC - 1) : CNT_W'(BUSY_CMD_CYC - 1);
`else
            state_n = S_IDLE;
`endif
        end
    end

    // State and control register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= 5'd0;
            cursor  <= 5'd0;
            id      <= 1'b1;
            disp    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cursor  <= cursor_n;
            id      <= id_n;
            disp    <= disp_n;
            cmd_err <= err_n;
        end
    end

`ifdef LCD_BUSY_EMU_EN
    // Busy countdown register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_n;
    end
`endif

    // Display RAM; reset restores all spaces (also discards a partial fill).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
        end else if (ram_we) begin
            ddram[ram_wa] <= ram_wd;
        end
    end

    assign busy        = (state != S_IDLE);
    assign cursor_addr = cursor;
    assign display_on  = disp;
    assign rd_char     = ddram[rd_index];
    assign lcd_data_oe = e_s2 & bus_rw;
    // instruction read returns {BF, HD44780 address}: line 2 starts at 0x40
    assign lcd_data_out = !lcd_data_oe ? 8'h00 :
                          bus_rs       ? ddram[cursor] :
                                         {busy, cursor[4], 2'b00, cursor[3:0]};

endmodule

// File: tb/tb_lcd_char_responder.sv
// Testbench for lcd_char_responder: vector table, corner sequences, and
// randomized accesses checked against a DDRAM/cursor reference model.
module tb_lcd_char_responder;

`ifdef LCD_BUSY_EMU_EN
    localparam int CMD_B = 20;
    localparam int CLR_B = 100;
`else
    localparam int CMD_B = 0;
    localparam int CLR_B = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data_in, lcd_data_out;
    logic       lcd_data_oe, busy, display_on, cmd_err;
    logic [4:0] cursor_addr, rd_index;
    logic [7:0] rd_char;

    lcd_char_responder #(.BUSY_CMD_CYC(20), .BUSY_CLR_CYC(100), .CNT_W(17)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .cursor_addr(cursor_addr), .display_on(display_on),
        .rd_index(rd_index), .rd_char(rd_char), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int busy_cyc = 0, err_seen = 0;

    always @(negedge clk) begin
        if (busy)    busy_cyc++;
        if (cmd_err) err_seen++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_ram [32];
    int m_cur, m_id, m_disp;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 32;
        m_cur = 0; m_id = 1; m_disp = 0;
    endtask

    task automatic m_step();
        m_cur = (m_cur + (m_id != 0 ? 1 : 31)) % 32;
    endtask

    task automatic m_apply(input bit rs, input bit rw, input int d, input bit now_busy,
                           output int e_err, output int e_busy, output int e_rd);
        int a;
        e_err = 0; e_busy = 0; e_rd = 0;
        if (rw) begin
            if (rs) begin
                if (now_busy) e_err = 1;
                else begin e_rd = m_ram[m_cur]; m_step(); end
            end
        end else if (now_busy) e_err = 1;
        else if (rs) begin
            m_ram[m_cur] = d; m_step(); e_busy = CMD_B;
        end else if (d >= 128) begin
            a = d % 128;
            if (a < 16) m_cur = a;
            else if (a >= 64 && a < 80) m_cur = a - 48;
            else e_err = 1;
            if (e_err == 0) e_busy = CMD_B;
        end else if (d >= 64) e_err = 1;
        else if (d >= 32) begin
            if ((d / 16) % 2 == 1) e_busy = CMD_B; else e_err = 1;
        end else if (d >= 16) e_busy = CMD_B;
        else if (d >= 8) begin m_disp = (d / 4) % 2; e_busy = CMD_B; end
        else if (d >= 4) begin m_id = (d / 2) % 2; e_busy = CMD_B; end
        else if (d >= 2) begin m_cur = 0; e_busy = CLR_B; end
        else if (d == 1) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 32;
            m_cur = 0; m_id = 1; e_busy = 32 + CLR_B;
        end
    endtask

    // ---------------- bus driver ----------------
    task automatic bus_op(input bit rs, input bit rw, input logic [7:0] d,
                          output logic [7:0] rdata, output logic roe);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
        repeat (2) @(negedge clk);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        rdata = lcd_data_out; roe = lcd_data_oe;
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s: busy still high after %0d cycles", name, n);
        end
    endtask

    // model-tracked op from idle, with busy/err deltas checked
    task automatic op_chk(input string name, input bit rs, input bit rw, input int d);
        int b0, e0, ee, eb, er;
        logic [7:0] rd;
        logic oe;
        b0 = busy_cyc; e0 = err_seen;
        m_apply(rs, rw, d, 1'b0, ee, eb, er);
        bus_op(rs, rw, 8'(d), rd, oe);
        wait_idle(name);
        chk({name, "_err"},  err_seen - e0, ee);
        chk({name, "_busy"}, busy_cyc - b0, eb);
        chk({name, "_cur"},  int'(cursor_addr), m_cur);
        chk({name, "_disp"}, int'(display_on), m_disp);
        if (rw && rs) chk({name, "_rd"}, int'(rd), er);
    endtask

    typedef struct {
        bit         rs;
        bit         rw;
        logic [7:0] d;
        int         cur;
        int         disp;
        int         nerr;
        int         kind;   // 0 none, 1 command busy, 2 home busy
    } vec_t;

    vec_t vecs [17];

    initial begin
        int b0, e0, ee, eb, er, sel, d, ri;
        bit rs, rw;
        logic [7:0] rd;
        logic oe;

        vecs[0]  = '{0, 0, 8'h0C,  0, 1, 0, 1};
        vecs[1]  = '{0, 0, 8'hC5, 21, 1, 0, 1};
        vecs[2]  = '{0, 0, 8'h90, 21, 1, 1, 0};
        vecs[3]  = '{0, 0, 8'h40, 21, 1, 1, 0};
        vecs[4]  = '{0, 0, 8'h20, 21, 1, 1, 0};
        vecs[5]  = '{0, 0, 8'h38, 21, 1, 0, 1};
        vecs[6]  = '{0, 0, 8'h1C, 21, 1, 0, 1};
        vecs[7]  = '{0, 0, 8'hCF, 31, 1, 0, 1};
        vecs[8]  = '{1, 0, 8'h41,  0, 1, 0, 1};
        vecs[9]  = '{0, 0, 8'h04,  0, 1, 0, 1};
        vecs[10] = '{1, 0, 8'h42, 31, 1, 0, 1};
        vecs[11] = '{0, 0, 8'h06, 31, 1, 0, 1};
        vecs[12] = '{0, 0, 8'h08, 31, 0, 0, 1};
        vecs[13] = '{0, 0, 8'h8F, 15, 0, 0, 1};
        vecs[14] = '{0, 0, 8'h03,  0, 0, 0, 2};
        vecs[15] = '{0, 0, 8'hD0,  0, 0, 1, 0};
        vecs[16] = '{0, 0, 8'h80,  0, 0, 0, 1};

        // ---- reset ----
        rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h00; rd_index = 5'd0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur", int'(cursor_addr), 0);
        chk("rst_disp", int'(display_on), 0);
        chk("rst_oe", int'(lcd_data_oe), 0);
        chk("rst_dout", int'(lcd_data_out), 0);
        chk("rst_err", int'(cmd_err), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i); #1;
            chk($sformatf("rst_char%0d", i), int'(rd_char), 8'h20);
        end

        // ---- vector table ----
        for (int i = 0; i < 17; i++) begin
            b0 = busy_cyc; e0 = err_seen;
            m_apply(vecs[i].rs, vecs[i].rw, int'(vecs[i].d), 1'b0, ee, eb, er);
            bus_op(vecs[i].rs, vecs[i].rw, vecs[i].d, rd, oe);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_cur", i), int'(cursor_addr), vecs[i].cur);
            chk($sformatf("vec%0d_disp", i), int'(display_on), vecs[i].disp);
            chk($sformatf("vec%0d_err", i), err_seen - e0, vecs[i].nerr);
            chk($sformatf("vec%0d_busy", i), busy_cyc - b0,
                vecs[i].kind == 1 ? CMD_B : (vecs[i].kind == 2 ? CLR_B : 0));
        end
        rd_index = 5'd31; #1; chk("wrap_char31", int'(rd_char), 8'h41);
        rd_index = 5'd0;  #1; chk("dec_char0", int'(rd_char), 8'h42);

        // ---- busy-flag/address read at cursor 18 ----
        m_apply(0, 0, 8'hC2, 1'b0, ee, eb, er);
        bus_op(0, 0, 8'hC2, rd, oe);
        bus_op(0, 1, 8'h00, rd, oe);
        chk("ird_busy_oe", int'(oe), 1);
        chk("ird_busy_val", int'(rd), CMD_B > 0 ? 8'hC2 : 8'h42);
        wait_idle("ird");
        bus_op(0, 1, 8'h00, rd, oe);
        chk("ird_idle_oe", int'(oe), 1);
        chk("ird_idle_val", int'(rd), 8'h42);
        chk("ird_cur", int'(cursor_addr), 18);
        chk("oe_released", int'(lcd_data_oe), 0);
        chk("dout_released", int'(lcd_data_out), 0);

        // ---- data read-back with cursor step ----
        op_chk("dwr55", 1, 0, 8'h55);
        op_chk("set18", 0, 0, 8'hD2);
        op_chk("drd", 1, 1, 0);

        // ---- fill RAM, clear, watch progress, reject write during fill ----
        op_chk("home0", 0, 0, 8'h80);
        op_chk("dispon", 0, 0, 8'h0C);
        for (int i = 0; i < 32; i++) op_chk($sformatf("fill%0d", i), 1, 0, 8'h30 + i);
        b0 = busy_cyc; e0 = err_seen;
        m_apply(0, 0, 1, 1'b0, ee, eb, er);
        bus_op(0, 0, 8'h01, rd, oe);
        rd_index = 5'd0;  #1; chk("clr_early0", int'(rd_char), 8'h20);
        rd_index = 5'd31; #1; chk("clr_early31", int'(rd_char), 8'h4F);
        bus_op(0, 1, 8'h00, rd, oe);
        chk("clr_ird", int'(rd), 8'h80);
        rd_index = 5'd10; #1; chk("clr_mid10", int'(rd_char), 8'h20);
        rd_index = 5'd20; #1; chk("clr_mid20", int'(rd_char), 8'h44);
        bus_op(1, 0, 8'h5A, rd, oe);
        wait_idle("clr");
        chk("clr_busy", busy_cyc - b0, 32 + CLR_B);
        chk("clr_err", err_seen - e0, 1);
        chk("clr_cur", int'(cursor_addr), 0);
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i); #1;
            chk($sformatf("clr_char%0d", i), int'(rd_char), m_ram[i]);
        end

        // ---- reset in the middle of a fill ----
        for (int i = 0; i < 4; i++) op_chk($sformatf("pre%0d", i), 1, 0, 8'h51);
        bus_op(0, 0, 8'h01, rd, oe);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_cur", int'(cursor_addr), 0);
        chk("mrst_disp", int'(display_on), 0);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 8; i++) begin
            rd_index = 5'(i); #1;
            chk($sformatf("mrst_char%0d", i), int'(rd_char), 8'h20);
        end

        // ---- randomized accesses against the model ----
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            rs = 1'b0; rw = 1'b0; d = 0;
            case (sel)
                0, 1, 2: begin rs = 1'b1; d = $urandom_range(32, 126); end
                3: d = 128 + ($urandom_range(0, 1) != 0 ? $urandom_range(0, 15) : 64 + $urandom_range(0, 15));
                4: d = 128 + $urandom_range(0, 127);
                5: d = $urandom_range(4, 7);
                6: d = $urandom_range(8, 15);
                7: d = $urandom_range(16, 127);
                8: begin rs = 1'b1; rw = 1'b1; end
                default: d = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 3);
            endcase
            op_chk($sformatf("rnd%0d", n), rs, rw, d);
            ri = $urandom_range(0, 31);
            rd_index = 5'(ri); #1;
            chk($sformatf("rnd%0d_char", n), int'(rd_char), m_ram[ri]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
